// File: rtl/block_sf_mult_sched.sv
// Stereo sum/difference scaler that time-shares one sequential multiplier:
// (L+R)<<3 * Ks first, then (L-R)<<3 * Kd, then both results commit together.
module block_sf_mult_sched #(
  parameter int N       = 18,
  parameter int M       = 4,
  parameter int TIMEOUT = 63
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                sample_strobe,
  input  logic signed [N-1:0] LEFT,
  input  logic signed [N-1:0] RIGHT,
  input  logic [M-1:0]        Ks,
  input  logic [M-1:0]        Kd,
  output logic                mult_start,
  output logic signed [N-1:0] mult_A,
  output logic signed [M:0]   mult_B,
  input  logic                mult_ready,
  input  logic signed [N-1:0] mult_R,
  output logic signed [N-1:0] LI_in_LpR,
  output logic signed [N-1:0] LI_in_LmR,
  output logic                out_valid,
  output logic                overrun,
  output logic                timeout_err,
  output logic [2:0]          o_dbg_state
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LP_WAIT_LAST = CW'(TIMEOUT - 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ISSUE_S = 3'd1;
  localparam logic [2:0] WAIT_S  = 3'd2;
  localparam logic [2:0] ISSUE_D = 3'd3;
  localparam logic [2:0] WAIT_D  = 3'd4;
  localparam logic [2:0] COMMIT  = 3'd5;

  logic [2:0]          r_state;
  logic signed [N-1:0] r_sum;
  logic signed [N-1:0] r_dif;
  logic signed [M:0]   r_bs;
  logic signed [M:0]   r_bd;
  logic signed [N-1:0] r_prod_s;
  logic signed [N-1:0] r_prod_d;
  logic [CW-1:0]       r_wait_cnt;
  logic signed [N-1:0] r_lpr;
  logic signed [N-1:0] r_lmr;
  logic                r_out_valid;
  logic                r_overrun;
  logic                r_timeout;

  logic signed [N-1:0] w_sum;
  logic signed [N-1:0] w_dif;
  logic                w_d_phase;

  assign w_sum = (LEFT + RIGHT) << 3;
  assign w_dif = (LEFT - RIGHT) << 3;
  assign w_d_phase = (r_state == ISSUE_D) || (r_state == WAIT_D);

  // Multiplier handshake: mult_start is a one-cycle request while mult_A/mult_B
  // are held steady; the multiplier drops mult_ready by the cycle after it
  // samples start and raises it with mult_R valid. WAIT states never look at
  // mult_ready during the ISSUE cycle, so a stale idle-ready cannot be taken.
  assign mult_start = (r_state == ISSUE_S) || (r_state == ISSUE_D);
  assign mult_A     = w_d_phase ? r_dif : r_sum;
  assign mult_B     = w_d_phase ? r_bd  : r_bs;

  assign LI_in_LpR   = r_lpr;
  assign LI_in_LmR   = r_lmr;
  assign out_valid   = r_out_valid;
  assign overrun     = r_overrun;
  assign timeout_err = r_timeout;
  assign o_dbg_state = r_state;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_sum       <= '0;
      r_dif       <= '0;
      r_bs        <= '0;
      r_bd        <= '0;
      r_prod_s    <= '0;
      r_prod_d    <= '0;
      r_wait_cnt  <= '0;
      r_lpr       <= '0;
      r_lmr       <= '0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      // Any strobe outside IDLE (COMMIT included) is dropped.
      if (sample_strobe && (r_state != IDLE)) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (sample_strobe) begin
            r_sum   <= w_sum;
            r_dif   <= w_dif;
            r_bs    <= {1'b0, Ks};
            r_bd    <= {1'b0, Kd};
            r_state <= ISSUE_S;
          end
        end
        ISSUE_S: begin
          r_wait_cnt <= '0;
          r_state    <= WAIT_S;
        end
        WAIT_S: begin
          if (mult_ready) begin
            r_prod_s <= mult_R;
            r_state  <= ISSUE_D;
          end else if (r_wait_cnt == LP_WAIT_LAST) begin
            r_timeout <= 1'b1;
            r_state   <= IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        ISSUE_D: begin
          r_wait_cnt <= '0;
          r_state    <= WAIT_D;
        end
        WAIT_D: begin
          if (mult_ready) begin
            r_prod_d <= mult_R;
            r_state  <= COMMIT;
          end else if (r_wait_cnt == LP_WAIT_LAST) begin
            r_timeout <= 1'b1;
            r_state   <= IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        COMMIT: begin
          r_lpr       <= r_prod_s;
          r_lmr       <= r_prod_d;
          r_out_valid <= 1'b1;
          r_state     <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/block_sf_mult_sched.md
BLOCK_SF_MULT_SCHED -- requirements
Module: block_sf_mult_sched

Interface
REQ-001 Parameter N, default 18: sample and product width.
REQ-002 Parameter M, default 4: gain constant width; operand B is M+1 bits, signed, with zero MSB.
REQ-003 Parameter TIMEOUT, default 63: maximum cycles allowed in a multiplier wait state.
REQ-004 clock  in  1  single system clock; all logic on posedge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 sample_strobe  in  1  one-cycle pulse marking a new 48 kHz stereo sample.
REQ-007 LEFT, RIGHT  in  N each  signed audio samples.
REQ-008 Ks, Kd  in  M each  unsigned gains for L+R and L-R.
REQ-009 mult_start  out  1  start pulse to the shared seqmultNM.
REQ-010 mult_A  out  N  signed multiplicand.
REQ-011 mult_B  out  M+1  signed multiplier.
REQ-012 mult_ready  in  1  seqmultNM idle/result-valid.
REQ-013 mult_R  in  N  seqmultNM product.
REQ-014 LI_in_LpR, LI_in_LmR  out  N each  registered scaled L+R and L-R.
REQ-015 out_valid  out  1  one-cycle pulse when both outputs update.
REQ-016 overrun  out  1  sticky: a strobe was dropped.
REQ-017 timeout_err  out  1  sticky: the multiplier failed to respond within TIMEOUT.

Function
REQ-018 The block SHALL time-share one seqmultNM between the L+R and L-R products, in the fixed order L+R first, then L-R.
REQ-019 On an accepted strobe, the block SHALL capture sum=(LEFT+RIGHT)<<3, dif=(LEFT-RIGHT)<<3 (both truncated to N bits), Bs={1'b0,Ks} and Bd={1'b0,Kd}; later input changes SHALL NOT affect the sample in flight.
REQ-020 The FSM SHALL have states IDLE, ISSUE_S, WAIT_S, ISSUE_D, WAIT_D and COMMIT.
REQ-021 IDLE: on sample_strobe, capture operands and go to ISSUE_S.
REQ-022 ISSUE_S: assert mult_start=1 for exactly one cycle with mult_A=sum and mult_B=Bs, then go to WAIT_S.
REQ-023 WAIT_S: when mult_ready=1, latch mult_R into the internal sum product and go to ISSUE_D.
REQ-024 ISSUE_D and WAIT_D SHALL behave like ISSUE_S and WAIT_S, using dif and Bd, and go to COMMIT.
REQ-025 COMMIT: load both LI_in_LpR and LI_in_LmR in the same cycle, pulse out_valid=1, and go to IDLE.
REQ-026 The multiplier contract SHALL be: mult_ready deasserts no later than the first cycle after mult_start is sampled, and rises when mult_R is valid; WAIT states SHALL NOT sample mult_ready in the ISSUE cycle.
REQ-027 mult_start SHALL be 0 in every state except ISSUE_S and ISSUE_D.
REQ-028 mult_A and mult_B SHALL hold their value from the ISSUE cycle through the end of the matching WAIT state.
REQ-029 Latency: with multiplier latency L (cycles from start sampled to ready high), out_valid SHALL assert 2L+4 cycles after the strobe cycle.
REQ-030 A strobe arriving in any state other than IDLE SHALL be dropped and SHALL set overrun; the sample in flight SHALL complete unaffected.
REQ-031 A strobe arriving in the COMMIT cycle SHALL count as an overrun.
REQ-032 A wait counter SHALL clear on entry to each WAIT state; if it reaches TIMEOUT, set timeout_err, abort without COMMIT (outputs unchanged, no out_valid), and go to IDLE.
REQ-033 Sticky flags SHALL clear only on reset.

Reset
REQ-034 While reset=1 at a clock edge: state=IDLE; LI_in_LpR, LI_in_LmR, out_valid, mult_start, overrun and timeout_err SHALL all be 0; captured operands and the wait counter SHALL be 0.
REQ-035 Reset asserted mid-operation SHALL abandon the sample with no out_valid pulse; the first strobe after reset SHALL be processed normally.

Verification
REQ-036 With LEFT=100, RIGHT=28, Ks=3, Kd=2 and a strobe, using a bench multiplier with L=20: out_valid is observed at strobe+44, with LI_in_LpR=3072 and LI_in_LmR=1152.
REQ-037 With LEFT=-50, RIGHT=30, Ks=1, Kd=15 and a strobe: LI_in_LpR=-160 and LI_in_LmR=-9600 (two's complement); exactly one out_valid pulse.
REQ-038 A second strobe issued 10 cycles after the first: overrun=1, exactly one out_valid, and results from the first sample only.
REQ-039 A bench multiplier that never raises ready after start: timeout_err=1 after TIMEOUT cycles, state returns to IDLE, outputs unchanged, and the next strobe with a working multiplier completes.
REQ-040 Reset pulsed during WAIT_D: all outputs are 0 on the next cycle, no out_valid, and the next strobe yields the correct products.
REQ-041 Changing LEFT/RIGHT/Ks/Kd on every cycle while busy: results match the values captured at the strobe, and mult_start has exactly two one-cycle pulses per sample.
